axis_stream_checker: RTL and testbench
======================================

# axis_stream_checker

AXI-Stream sink that terminates the FIFO master port and consumes packets produced by the stream source. It drives `S_TReady` from a programmable back-pressure pattern and checks every accepted beat against a descending-counter reference. It also checks packet length via `S_TLast` and reports counts, sticky error flags and completion. It sits downstream of the FIFO in simulation and on-chip loopback self-test.

## Interface
- `WIDTH`, 8: data bus width.
- `PKT_LEN`, 8: expected beats per packet, ≥1.
- `NUM_PKTS`, 4: packets to accept before `done`, ≥1.
- `SEED`, 8: expected value of the first beat after reset, taken mod 2^WIDTH.
- `READY_PAT`, 8'hFF: 8-bit back-pressure pattern, rotated LSB-first. A 1 means ready in that slot.

- `CLK`  in  1  clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Enable`  in  1  starts reception from IDLE; ignored afterwards.
- `S_TData`  in  [0:WIDTH-1]  beat data.
- `S_TValid`  in  1  source has a beat.
- `S_TLast`  in  1  last beat of packet.
- `S_TReady`  out  1  checker accepts a beat this cycle; registered.
- `pkt_count`  out  16  packets accepted, counted on accepted `S_TLast`.
- `beat_count`  out  16  total beats accepted.
- `data_err`  out  1  sticky; an accepted beat mismatched the expected value.
- `len_err`  out  1  sticky; a packet length ≠ `PKT_LEN`.
- `err_beat`  out  16  `beat_count` value at the first error of either kind.
- `done`  out  1  `NUM_PKTS` packets accepted.

## Operation
- FSM states:
  - IDLE: entered at reset. Moves to RECV on `Enable`=1.
  - RECV: moves to DONE on acceptance of the `NUM_PKTS`-th `S_TLast`.
  - DONE: terminal until `Reset`.
- Accept means `S_TValid & S_TReady` at a rising edge.
- `S_TReady` is 1 only in RECV when the current pattern bit is 1.
- Pattern pointer (3 bits) starts at 0 and advances every cycle spent in RECV, whether or not a beat is accepted. It wraps 7→0.
- Expected value `exp` starts at `SEED`. On each accept it becomes `exp-1` mod 2^WIDTH, so 0 wraps to all-ones. It runs continuously across packet boundaries.
- `data_err` is set when `S_TData≠exp` on an accepted beat. `exp` still decrements; it does not resynchronise.
- Beat index `idx` runs within the packet. It is 0 at packet start and increments on each accept.
  - On accepted `S_TLast`: `len_err` is set if `idx≠PKT_LEN-1`. Then `idx` returns to 0 and `pkt_count` increments.
  - Overrun: if a beat is accepted with `idx=PKT_LEN-1` and `S_TLast`=0, `len_err` is set immediately and `idx` saturates. It is reported once per packet.
- `err_beat` latches the pre-increment `beat_count` on the first cycle in which either flag goes 0→1. Later errors do not change it.
- Counters are 16-bit and wrap silently.
- `S_TValid` high in IDLE/DONE is not accepted and is not an error.
- Reset mid-packet returns to IDLE, clears all state and reloads `exp=SEED`. A partial packet is discarded.

## Timing
- Reset values: `S_TReady`=0, `pkt_count`=0, `beat_count`=0, `data_err`=0, `len_err`=0, `err_beat`=0, `done`=0. Pattern pointer is 0.
- Entry into RECV: `Enable` sampled at edge N → FSM in RECV after edge N. `S_TReady` equals `READY_PAT[0]` from edge N onward, so the first accept can occur at edge N+1.
- All status outputs update at the edge of the accept and are visible the following cycle.
- `done` and the drop of `S_TReady` to 0 occur at the same edge that accepts the final `S_TLast`.
- With `READY_PAT`=8'hFF and continuous valid, throughput is 1 beat/cycle.

## Structure
- Package `axis_pkg`:
  - `typedef enum logic [1:0] {IDLE, RECV, DONE} chk_state_t`;
  - counter width constant `CNT_W=16`.
- Sub-module `axis_ready_gen`: rotating pattern register with pointer and enable. It outputs the registered ready bit and is reusable by other sinks.
- The checker body holds the FSM, `exp`, `idx`, counters and error latching.

## Test plan
- In-order stream: defaults, source sends 8,7,…,1 per packet continuing the countdown, 4 packets, `S_TLast` on every 8th beat → `pkt_count`=4, `beat_count`=32, `done`=1, both errors 0, `S_TReady`=0 afterwards.
- Back-pressure: `READY_PAT`=8'b0101_0101 with continuous valid → accepts exactly on alternate cycles. Data and counts are the same as in-order; no errors.
- Data corruption: beat 5 (global index 5) driven 8'hAA instead of 8'h03 → `data_err`=1 and `err_beat`=5. `exp` continues, so later beats produce no further change to `err_beat`.
- Length errors:
  - `S_TLast` on the 6th beat → `len_err`=1 at that accept, `pkt_count` increments.
  - 9 beats without `S_TLast` → `len_err` set on the 8th beat.
- Wrap: `SEED`=1 → expected 1, 0, 8'hFF, 8'hFE…; a correct source gives no `data_err`.
- Reset mid-packet: `Reset` after 3 beats → all outputs return to reset values next cycle. After `Enable` is reasserted, a fresh stream from `SEED` passes clean.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream checker sink.
package axis_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {IDLE, RECV, DONE} chk_state_t;

endpackage

// File: rtl/axis_ready_gen.sv
// Registered back-pressure generator: walks an 8-slot pattern while advancing,
// presenting the selected slot as a registered ready bit.
module axis_ready_gen #(
   parameter logic [7:0] PATTERN = 8'hFF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic advance_i,
   output logic ready_o
);

   logic [2:0] ptr_q, ptr_d;
   logic       ready_q, ready_d;

   // Ready for the coming cycle is looked up with the already-advanced pointer.
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = ptr_q + 3'd1;
      end
      ready_d = en_i & PATTERN[ptr_d];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q   <= 3'd0;
         ready_q <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         ready_q <= ready_d;
      end
   end

   assign ready_o = ready_q;

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks a descending-counter payload and packet length,
// reporting counts, sticky error flags and completion.
//
// state | meaning
// IDLE  | waiting for Enable, ready held low
// RECV  | accepting beats per ready pattern
// DONE  | NUM_PKTS packets accepted, terminal until Reset
module axis_stream_checker
   import axis_pkg::*;
#(
   parameter int         WIDTH     = 8,
   parameter int         PKT_LEN   = 8,
   parameter int         NUM_PKTS  = 4,
   parameter int         SEED      = 8,
   parameter logic [7:0] READY_PAT = 8'hFF
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [0:WIDTH-1] S_TData,
   input  logic             S_TValid,
   input  logic             S_TLast,
   output logic             S_TReady,
   output logic [15:0]      pkt_count,
   output logic [15:0]      beat_count,
   output logic             data_err,
   output logic             len_err,
   output logic [15:0]      err_beat,
   output logic             done
);

   localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PKT_LEN - 1);
   localparam logic [CNT_W-1:0] FINAL_PKT = CNT_W'(NUM_PKTS - 1);

   chk_state_t       state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
   logic [CNT_W-1:0] beat_count_q, beat_count_d;
   logic [CNT_W-1:0] err_beat_q, err_beat_d;
   logic             data_err_q, data_err_d;
   logic             len_err_q, len_err_d;

   logic ready;
   logic accept;
   logic at_last;
   logic data_hit;
   logic len_hit;

   axis_ready_gen #(
      .PATTERN (READY_PAT)
   ) u_ready_gen (
      .clk_i     (CLK),
      .rst_i     (Reset),
      .en_i      (state_d == RECV),
      .advance_i (state_q == RECV),
      .ready_o   (ready)
   );

   assign accept   = S_TValid & ready & (state_q == RECV);
   assign at_last  = (idx_q == LAST_IDX);
   assign data_hit = accept & (S_TData != exp_q);
   // Early TLast, or a beat past the expected length without TLast (overrun).
   assign len_hit  = accept & (S_TLast ? ~at_last : at_last);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Enable) state_d = RECV;
         RECV:    if (accept && S_TLast && (pkt_count_q == FINAL_PKT)) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      exp_d        = exp_q;
      idx_d        = idx_q;
      pkt_count_d  = pkt_count_q;
      beat_count_d = beat_count_q;
      err_beat_d   = err_beat_q;
      data_err_d   = data_err_q | data_hit;
      len_err_d    = len_err_q | len_hit;
      if (accept) begin
         exp_d        = exp_q - 1'b1;
         beat_count_d = beat_count_q + 1'b1;
         if (S_TLast) begin
            idx_d       = '0;
            pkt_count_d = pkt_count_q + 1'b1;
         end else if (!at_last) begin
            idx_d = idx_q + 1'b1;
         end
      end
      if (!data_err_q && !len_err_q && (data_hit || len_hit)) begin
         err_beat_d = beat_count_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= IDLE;
         exp_q        <= SEED_W;
         idx_q        <= '0;
         pkt_count_q  <= '0;
         beat_count_q <= '0;
         err_beat_q   <= '0;
         data_err_q   <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         idx_q        <= idx_d;
         pkt_count_q  <= pkt_count_d;
         beat_count_q <= beat_count_d;
         err_beat_q   <= err_beat_d;
         data_err_q   <= data_err_d;
         len_err_q    <= len_err_d;
      end
   end

   assign S_TReady   = ready;
   assign pkt_count  = pkt_count_q;
   assign beat_count = beat_count_q;
   assign data_err   = data_err_q;
   assign len_err    = len_err_q;
   assign err_beat   = err_beat_q;
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_axis_stream_checker.sv
// Scoreboard bench for axis_stream_checker: three parameterisations share one
// stimulus driver; the selected instance's outputs feed the monitor.
module tb_axis_stream_checker;

   typedef struct packed {
      logic [15:0] pkt;
      logic [15:0] beat;
      logic        derr;
      logic        lerr;
      logic [15:0] ebeat;
      logic        done;
   } st_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;

   logic        rdy[3];
   logic [15:0] pkt[3];
   logic [15:0] beat[3];
   logic        derr[3];
   logic        lerr[3];
   logic [15:0] ebeat[3];
   logic        dn[3];

   int          sel = 0;
   logic        rdy_m, derr_m, lerr_m, done_m;
   logic [15:0] pkt_m, beat_m, ebeat_m;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   st_t  sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_stream_checker dut_def (
      .CLK(clk), .Reset(reset), .Enable(enable), .S_TData(s_data), .S_TValid(s_valid),
      .S_TLast(s_last), .S_TReady(rdy[0]), .pkt_count(pkt[0]), .beat_count(beat[0]),
      .data_err(derr[0]), .len_err(lerr[0]), .err_beat(ebeat[0]), .done(dn[0]));

   axis_stream_checker #(.READY_PAT(8'b0101_0101)) dut_bp (
      .CLK(clk), .Reset(reset), .Enable(enable), .S_TData(s_data), .S_TValid(s_valid),
      .S_TLast(s_last), .S_TReady(rdy[1]), .pkt_count(pkt[1]), .beat_count(beat[1]),
      .data_err(derr[1]), .len_err(lerr[1]), .err_beat(ebeat[1]), .done(dn[1]));

   axis_stream_checker #(.SEED(1)) dut_wrap (
      .CLK(clk), .Reset(reset), .Enable(enable), .S_TData(s_data), .S_TValid(s_valid),
      .S_TLast(s_last), .S_TReady(rdy[2]), .pkt_count(pkt[2]), .beat_count(beat[2]),
      .data_err(derr[2]), .len_err(lerr[2]), .err_beat(ebeat[2]), .done(dn[2]));

   always_comb begin
      rdy_m   = rdy[sel];
      pkt_m   = pkt[sel];
      beat_m  = beat[sel];
      derr_m  = derr[sel];
      lerr_m  = lerr[sel];
      ebeat_m = ebeat[sel];
      done_m  = dn[sel];
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic st_t mk(input int p, input int b, input logic de, input logic le,
                              input int eb, input logic d);
      st_t s;
      s.pkt = 16'(p); s.beat = 16'(b); s.derr = de; s.lerr = le; s.ebeat = 16'(eb); s.done = d;
      return s;
   endfunction

   // Monitor: an accept is decided mid-cycle, its effect is compared just after the edge.
   initial begin
      logic acc;
      st_t  e;
      forever begin
         @(negedge clk);
         acc = s_valid & rdy_m;
         @(posedge clk);
         #1;
         if (acc) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: unexpected accept, beat_count %0d", beat_m);
            end else begin
               e = sb.pop_front();
               chk("pkt_count", pkt_m, e.pkt);
               chk("beat_count", beat_m, e.beat);
               chk("data_err", 16'(derr_m), 16'(e.derr));
               chk("len_err", 16'(lerr_m), 16'(e.lerr));
               chk("err_beat", ebeat_m, e.ebeat);
               chk("done", 16'(done_m), 16'(e.done));
            end
         end
      end
   end

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic send(input logic [7:0] d, input logic l, input st_t e);
      int n;
      n = 0;
      s_data  = d;
      s_last  = l;
      s_valid = 1'b1;
      sb.push_back(e);
      forever begin
         @(negedge clk);
         if (rdy_m) break;
         n++;
         if (n > 40) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: beat %0h not accepted", d);
            break;
         end
      end
      @(posedge clk);
      #2;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      enable  = 1'b0;
      reset   = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      chk("rst_ready", 16'(rdy_m), 16'h0);
      chk("rst_pkt", pkt_m, 16'h0);
      chk("rst_beat", beat_m, 16'h0);
      chk("rst_derr", 16'(derr_m), 16'h0);
      chk("rst_lerr", 16'(lerr_m), 16'h0);
      chk("rst_ebeat", ebeat_m, 16'h0);
      chk("rst_done", 16'(done_m), 16'h0);
   endtask

   task automatic do_enable(output int t0);
      enable = 1'b1;
      @(posedge clk);
      #2;
      enable = 1'b0;
      t0 = cyc;
   endtask

   // Well-formed 8-beat packets counting down from seed; bad_i >= 0 corrupts that beat.
   task automatic stream(input int n, input int seed, input int bad_i);
      logic [7:0] d;
      logic       de;
      for (int i = 0; i < n; i++) begin
         d  = (i == bad_i) ? 8'hAA : 8'(seed - i);
         de = (bad_i >= 0) && (i >= bad_i);
         send(d, (i % 8) == 7, mk((i + 1) / 8, i + 1, de, 1'b0, de ? bad_i : 0, (i + 1) == 32));
      end
   endtask

   initial begin
      int t0;
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      @(posedge clk);
      #2;

      // In-order stream, full rate
      sel = 0;
      do_reset();
      do_enable(t0);
      chk("ready_on_entry", 16'(rdy_m), 16'h1);
      stream(32, 8, -1);
      chk("inorder_cycles", 16'(cyc - t0), 16'd32);
      chk("inorder_ready_after", 16'(rdy_m), 16'h0);
      s_valid = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      s_valid = 1'b0;
      chk("done_no_accept", beat_m, 16'd32);
      chk("done_hold", 16'(done_m), 16'h1);

      // Alternate-slot back-pressure
      sel = 1;
      do_reset();
      do_enable(t0);
      stream(32, 8, -1);
      chk("bp_cycles", 16'(cyc - t0), 16'd63);
      chk("bp_ready_after", 16'(rdy_m), 16'h0);

      // Countdown through zero
      sel = 2;
      do_reset();
      do_enable(t0);
      stream(10, 1, -1);

      // Corrupted beat 5
      sel = 0;
      do_reset();
      do_enable(t0);
      stream(16, 8, 5);

      // Short packet: TLast on 6th beat, then a clean packet
      do_reset();
      do_enable(t0);
      for (int i = 0; i < 6; i++)
         send(8'(8 - i), i == 5, mk((i == 5) ? 1 : 0, i + 1, 1'b0, i == 5, (i == 5) ? 5 : 0, 1'b0));
      for (int i = 6; i < 14; i++)
         send(8'(8 - i), i == 13, mk((i == 13) ? 2 : 1, i + 1, 1'b0, 1'b1, 5, 1'b0));

      // Overrun: 9 beats without TLast, then a TLast
      do_reset();
      do_enable(t0);
      for (int i = 0; i < 9; i++)
         send(8'(8 - i), 1'b0, mk(0, i + 1, 1'b0, i >= 7, (i >= 7) ? 7 : 0, 1'b0));
      send(8'(8 - 9), 1'b1, mk(1, 10, 1'b0, 1'b1, 7, 1'b0));

      // Reset mid-packet, then a clean full run
      do_reset();
      do_enable(t0);
      for (int i = 0; i < 3; i++)
         send(8'(8 - i), 1'b0, mk(0, i + 1, 1'b0, 1'b0, 0, 1'b0));
      do_reset();
      do_enable(t0);
      stream(32, 8, -1);
      chk("rerun_done", 16'(done_m), 16'h1);

      chk("sb_empty", 16'(sb.size()), 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
